// File: rtl/mealy_out_packer_if.sv
// Handshake bundle for mealy_out_packer: pair-capture inputs on one side and
// the FWFT word FIFO on the other. out_parity exists only with MEALY_PACKER_PARITY_EN.
interface mealy_out_packer_if #(
  parameter int DEPTH = 4
);
  logic                       en;
  logic                       b1;
  logic                       b2;
  logic                       flush;
  logic [7:0]                 out_data;
  logic                       out_valid;
  logic                       out_ready;
  logic [$clog2(DEPTH):0]     fifo_count;
  logic                       overflow;
`ifdef MEALY_PACKER_PARITY_EN
  logic                       out_parity;
`endif

  modport master (
    output en, b1, b2, flush, out_ready,
`ifdef MEALY_PACKER_PARITY_EN
    input  out_parity,
`endif
    input  out_data, out_valid, fifo_count, overflow
  );

  modport slave (
    input  en, b1, b2, flush, out_ready,
`ifdef MEALY_PACKER_PARITY_EN
    output out_parity,
`endif
    output out_data, out_valid, fifo_count, overflow
  );
endinterface

// File: rtl/mealy_out_packer.sv
// Packs four {b2,b1} Mealy output pairs into a byte and queues it in a FWFT FIFO.
// Define MEALY_PACKER_PARITY_EN to add out_parity (XOR of out_data).
module mealy_out_packer #(
  parameter int DEPTH = 4
) (
  input  logic                Clk,
  input  logic                reset,
  mealy_out_packer_if.slave   bus
);

  localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int CW = $clog2(DEPTH) + 1;

  typedef enum logic [1:0] {SLOT0, SLOT1, SLOT2, SLOT3} slot_e;

  slot_e           slot_q, slot_d;
  logic [5:0]      partial_q, partial_d;
  logic            complete;
  logic [1:0]      pair;
  logic [7:0]      word;

  logic [7:0]      mem [DEPTH];
  logic [PW-1:0]   rd_ptr_q, wr_ptr_q;
  logic [CW-1:0]   count_q;
  logic            overflow_q;
  logic            full, empty, pop, push, drop;

  assign pair = {bus.b2, bus.b1};
  assign word = {pair, partial_q};

  // NOTE: state registers use non-blocking assignments so every flop samples
  // pre-edge values regardless of process ordering.
  always_ff @(posedge Clk or negedge reset) begin
    if (!reset) begin
      slot_q    <= SLOT0;
      partial_q <= '0;
    end else begin
      slot_q    <= slot_d;
      partial_q <= partial_d;
    end
  end

  // NOTE: every always_comb output gets a default first so no path leaves it
  // unassigned, which would otherwise infer a latch.
  always_comb begin
    slot_d    = slot_q;
    partial_d = partial_q;
    complete  = 1'b0;
    if (bus.flush) begin
      slot_d    = SLOT0;
      partial_d = '0;
    end else if (bus.en) begin
      unique case (slot_q)
        SLOT0: begin partial_d[1:0] = pair; slot_d = SLOT1; end
        SLOT1: begin partial_d[3:2] = pair; slot_d = SLOT2; end
        SLOT2: begin partial_d[5:4] = pair; slot_d = SLOT3; end
        SLOT3: begin
          complete  = 1'b1;
          partial_d = '0;
          slot_d    = SLOT0;
        end
        default: slot_d = SLOT0;
      endcase
    end
  end

  assign empty = (count_q == '0);
  assign full  = (count_q == CW'(DEPTH));
  assign pop   = bus.out_ready && !empty;
  // A full FIFO still accepts a word when the head leaves on the same edge.
  assign push  = complete && (!full || pop);
  assign drop  = complete && full && !pop;

  always_ff @(posedge Clk or negedge reset) begin
    if (!reset) begin
      rd_ptr_q   <= '0;
      wr_ptr_q   <= '0;
      count_q    <= '0;
      overflow_q <= 1'b0;
    end else begin
      if (pop)  rd_ptr_q <= rd_ptr_q + PW'(1);
      if (push) wr_ptr_q <= wr_ptr_q + PW'(1);
      unique case ({push, pop})
        2'b10:   count_q <= count_q + CW'(1);
        2'b01:   count_q <= count_q - CW'(1);
        default: count_q <= count_q;
      endcase
      if (drop) overflow_q <= 1'b1;
    end
  end

  // NOTE: the storage array has no reset; empty-gating of out_data hides its
  // contents until a word has been written.
  always_ff @(posedge Clk) begin
    if (push) mem[wr_ptr_q] <= word;
  end

  assign bus.out_valid  = !empty;
  assign bus.out_data   = empty ? 8'h00 : mem[rd_ptr_q];
  assign bus.fifo_count = count_q;
  assign bus.overflow   = overflow_q;
`ifdef MEALY_PACKER_PARITY_EN
  assign bus.out_parity = ^bus.out_data;
`endif

endmodule

// File: tb/tb_mealy_out_packer.sv
// Self-checking bench for mealy_out_packer: directed scenarios then random
// traffic, compared every cycle against a queue-based reference model.
module tb_mealy_out_packer;

  localparam int DEPTH = 4;

  logic clk;
  logic reset;
  int   checks = 0;
  int   errors = 0;

  mealy_out_packer_if #(.DEPTH(DEPTH)) bus ();

  mealy_out_packer #(.DEPTH(DEPTH)) dut (
    .Clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Reference model: captured pairs of the word in progress, queued words.
  logic [1:0] pairs_q [$];
  logic [7:0] fifo_q  [$];
  logic       ovf_m;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic check_outputs(input string tag);
    logic [7:0] exp_data;
    exp_data = (fifo_q.size() > 0) ? fifo_q[0] : 8'h00;
    check({tag, ".data"},  32'(bus.out_data),   32'(exp_data));
    check({tag, ".valid"}, 32'(bus.out_valid),  32'(fifo_q.size() > 0));
    check({tag, ".count"}, 32'(bus.fifo_count), 32'(fifo_q.size()));
    check({tag, ".ovf"},   32'(bus.overflow),   32'(ovf_m));
`ifdef MEALY_PACKER_PARITY_EN
    check({tag, ".par"},   32'(bus.out_parity), 32'(^exp_data));
`endif
  endtask

  task automatic model_edge(input logic en, input logic [1:0] p, input logic fl, input logic rdy);
    logic       do_pop;
    logic       done;
    logic [7:0] w;
    do_pop = (fifo_q.size() > 0) && rdy;
    done   = 1'b0;
    w      = 8'h00;
    if (fl) pairs_q.delete();
    else if (en) begin
      pairs_q.push_back(p);
      if (pairs_q.size() == 4) begin
        for (int i = 0; i < 4; i++) w[2*i +: 2] = pairs_q[i];
        pairs_q.delete();
        done = 1'b1;
      end
    end
    if (do_pop) void'(fifo_q.pop_front());
    if (done) begin
      if (fifo_q.size() < DEPTH) fifo_q.push_back(w);
      else ovf_m = 1'b1;
    end
  endtask

  task automatic model_reset();
    pairs_q.delete();
    fifo_q.delete();
    ovf_m = 1'b0;
  endtask

  task automatic set_idle();
    bus.en = 1'b0; bus.b1 = 1'b0; bus.b2 = 1'b0; bus.flush = 1'b0; bus.out_ready = 1'b0;
  endtask

  // One clock: drive after the falling edge, step the model, check #1 past the rising edge.
  task automatic cycle(input string tag, input logic en, input logic [1:0] p,
                       input logic fl, input logic rdy);
    @(negedge clk);
    bus.en = en; bus.b2 = p[1]; bus.b1 = p[0]; bus.flush = fl; bus.out_ready = rdy;
    model_edge(en, p, fl, rdy);
    @(posedge clk);
    #1;
    check_outputs(tag);
    set_idle();
  endtask

  task automatic pack_word(input string tag, input logic [7:0] w, input logic rdy_last);
    for (int k = 0; k < 4; k++)
      cycle(tag, 1'b1, w[2*k +: 2], 1'b0, (k == 3) ? rdy_last : 1'b0);
  endtask

  task automatic drain(input string tag);
    for (int k = 0; k < DEPTH + 1; k++) cycle(tag, 1'b0, 2'b00, 1'b0, 1'b1);
  endtask

  task automatic pulse_reset(input string tag);
    @(negedge clk);
    reset = 1'b0;
    #1;
    model_reset();
    check_outputs(tag);
    @(negedge clk);
    reset = 1'b1;
  endtask

  initial begin
    logic [7:0] got;
    reset = 1'b0;
    set_idle();
    model_reset();
    repeat (2) @(negedge clk);
    #1;
    check_outputs("reset");
    reset = 1'b1;

    // Basic pack: 01,10,11,00 -> 8'h39
    cycle("pack0", 1'b1, 2'b01, 1'b0, 1'b0);
    cycle("pack1", 1'b1, 2'b10, 1'b0, 1'b0);
    cycle("pack2", 1'b1, 2'b11, 1'b0, 1'b0);
    check("pack.novalid", 32'(bus.out_valid), 32'd0);
    cycle("pack3", 1'b1, 2'b00, 1'b0, 1'b0);
    check("pack.word", 32'(bus.out_data), 32'h39);
    check("pack.cnt1", 32'(bus.fifo_count), 32'd1);
`ifdef MEALY_PACKER_PARITY_EN
    check("par.39", 32'(bus.out_parity), 32'd0);
`endif
    drain("pack.drain");

    // Enable gaps between pairs 2 and 3
    cycle("gap0", 1'b1, 2'b01, 1'b0, 1'b0);
    cycle("gap1", 1'b1, 2'b10, 1'b0, 1'b0);
    for (int k = 0; k < 3; k++) cycle("gap.idle", 1'b0, 2'b11, 1'b0, 1'b0);
    cycle("gap2", 1'b1, 2'b11, 1'b0, 1'b0);
    check("gap.novalid", 32'(bus.out_valid), 32'd0);
    cycle("gap3", 1'b1, 2'b00, 1'b0, 1'b0);
    check("gap.word", 32'(bus.out_data), 32'h39);
    drain("gap.drain");

`ifdef MEALY_PACKER_PARITY_EN
    pack_word("par38", 8'h38, 1'b0);
    check("par.38", 32'(bus.out_parity), 32'd1);
    drain("par.drain");
`endif

    // Full / overflow: five 8'hFF words into a depth-4 FIFO
    for (int k = 0; k < 5; k++) pack_word("ovf.fill", 8'hFF, 1'b0);
    check("ovf.cnt", 32'(bus.fifo_count), 32'(DEPTH));
    check("ovf.flag", 32'(bus.overflow), 32'd1);
    drain("ovf.drain");
    check("ovf.sticky", 32'(bus.overflow), 32'd1);

    // Simultaneous push and pop while full
    pulse_reset("rst.a");
    for (int k = 1; k <= DEPTH; k++) pack_word("pp.fill", 8'(k), 1'b0);
    pack_word("pp.push", 8'hC3, 1'b1);
    check("pp.cnt", 32'(bus.fifo_count), 32'(DEPTH));
    check("pp.ovf", 32'(bus.overflow), 32'd0);
    got = 8'h00;
    for (int k = 0; k < DEPTH; k++) begin
      got = bus.out_data;
      cycle("pp.drain", 1'b0, 2'b00, 1'b0, 1'b1);
    end
    check("pp.last", 32'(got), 32'hC3);

    // Flush mid-word
    cycle("fl0", 1'b1, 2'b10, 1'b0, 1'b0);
    cycle("fl1", 1'b1, 2'b11, 1'b0, 1'b0);
    cycle("fl.edge", 1'b1, 2'b10, 1'b1, 1'b0);
    pack_word("fl.word", 8'h55, 1'b0);
    check("fl.55", 32'(bus.out_data), 32'h55);
    drain("fl.drain");

    // Reset mid-word
    cycle("rm0", 1'b1, 2'b10, 1'b0, 1'b0);
    cycle("rm1", 1'b1, 2'b11, 1'b0, 1'b0);
    pulse_reset("rst.b");
    pack_word("rm.word", 8'h55, 1'b0);
    check("rm.55", 32'(bus.out_data), 32'h55);
    drain("rm.drain");

    // Random traffic
    for (int n = 0; n < 800; n++) begin
      if ($urandom_range(0, 249) == 0) pulse_reset("rnd.rst");
      else cycle("rnd",
                 1'($urandom_range(0, 3) != 0),
                 2'($urandom_range(0, 3)),
                 1'($urandom_range(0, 19) == 0),
                 1'($urandom_range(0, 2) == 0));
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/mealy_out_packer.md
MEALY_OUT_PACKER -- requirements
Module: mealy_out_packer

Interface
REQ-001 SHALL have parameter: DEPTH, 4, FIFO depth in words; power of two, 2..16.
REQ-002 SHALL have port: Clk  input  1  single rising-edge clock for all state.
REQ-003 SHALL have port: reset  input  1  asynchronous, active-low reset.
REQ-004 SHALL have port: en  input  1  sample enable; the {b2,b1} pair is captured on a Clk edge when high.
REQ-005 SHALL have port: b1  input  1  Mealy output bit 1 from the upstream sequence stage.
REQ-006 SHALL have port: b2  input  1  Mealy output bit 2 from the upstream sequence stage.
REQ-007 SHALL have port: flush  input  1  discards the partially packed word.
REQ-008 SHALL have port: out_data  output  8  FIFO head word, first-word-fall-through.
REQ-009 SHALL have port: out_valid  output  1  high while FIFO is non-empty.
REQ-010 SHALL have port: out_ready  input  1  consumer accept; a pop occurs on an edge where out_valid and out_ready are both high.
REQ-011 SHALL have port: fifo_count  output  $clog2(DEPTH)+1  number of stored words.
REQ-012 SHALL have port: overflow  output  1  sticky flag set when a completed word is dropped.

Function
REQ-013 SHALL keep a 2-bit slot counter (states SLOT0..SLOT3); each edge with en=1 and flush=0 stores {b2,b1} at out-word bits [2k+1:2k], k=slot, then slot advances; SLOT3 wraps to SLOT0.
REQ-014 SHALL, on the edge that captures the SLOT3 pair, write the completed word (3 held pairs plus the current pair) into the FIFO on that same edge; out_valid rises after that edge if the FIFO was empty.
REQ-015 SHALL hold the slot counter and partial word unchanged on edges with en=0.
REQ-016 SHALL, on an edge with flush=1, clear the slot to SLOT0 and the partial word to 0, ignore en, and leave FIFO contents and count untouched.
REQ-017 SHALL drive out_data=8'h00 when the FIFO is empty; otherwise drive the oldest word.
REQ-018 SHALL, when a word completes while fifo_count==DEPTH and no pop occurs on that edge, drop the word, set overflow, and still wrap the slot to SLOT0.
REQ-019 SHALL, on simultaneous push and pop when full, accept the push; fifo_count stays DEPTH and overflow is not set.
REQ-020 SHALL, on simultaneous push and pop when non-full and non-empty, leave fifo_count unchanged.
REQ-021 SHALL ignore out_ready when the FIFO is empty; there is no underflow and no state change.
REQ-022 SHALL wrap the read and write pointers modulo DEPTH.

Reset
REQ-023 SHALL, while reset=0, immediately force slot=SLOT0, partial word=0, pointers=0, fifo_count=0, out_valid=0, out_data=8'h00, overflow=0, independent of Clk.
REQ-024 SHALL discard any partial word and all FIFO contents when reset asserts mid-operation; packing restarts at SLOT0 on the first edge after reset=1.
REQ-025 SHALL clear overflow only by reset.

Configuration
REQ-026 SHALL, with macro MEALY_PACKER_PARITY_EN defined, add output out_parity (1 bit) equal to the XOR of the 8 out_data bits, which is 0 when empty.
REQ-027 SHALL, without MEALY_PACKER_PARITY_EN, omit out_parity entirely; all other behaviour is identical.

Verification
REQ-028 SHALL cover basic pack: reset release, en=1, out_ready=0, pairs {b2,b1}=01,10,11,00 -> out_data=8'h39, out_valid=1, fifo_count=1 after the 4th edge.
REQ-029 SHALL cover enable gaps: the same four pairs with en=0 for 3 cycles between pairs 2 and 3 -> result still 8'h39, with no word before the 4th enabled edge.
REQ-030 SHALL cover full/overflow: DEPTH=4, out_ready=0, 5 words of 8'hFF (all pairs 11) -> fifo_count=4, overflow=1; then out_ready=1 drains 4 words of 8'hFF; overflow stays 1.
REQ-031 SHALL cover simultaneous push and pop when full: FIFO full and the 4th pair arrives with out_ready=1 -> count stays 4, overflow=0, and the new word is the last one out.
REQ-032 SHALL cover flush and reset mid-word: after 2 pairs, flush=1 for one edge, then pairs 01,01,01,01 -> 8'h55; repeating with reset pulsed low mid-word gives the same 8'h55 and all outputs at reset values during the pulse.
REQ-033 SHALL cover parity: with MEALY_PACKER_PARITY_EN defined, 8'h39 -> out_parity=0 and 8'h38 -> out_parity=1.
